stage_scroller: RTL and testbench
=================================

// Module: stage_scroller
// PURPOSE
//  Consumer end of the stage-generation interface. Holds the two on-screen stages (home, target),
//  judges each player landing against them, scrolls the target stage back to HOME_X one frame at a
//  time, then pulses gen_enable to generate_stage and loads the new pair. Sits between
//  generate_stage and the VGA renderer / player-jump logic.
// PARAMETERS
//  HOME_X   60  x (left edge, pixels) where the target stage comes to rest after a scroll
//  STEP     4   pixels moved per frame_tick while scrolling
//  GEN_LAT  2   clk cycles from gen_enable pulse until stage_*_in are valid
//  SCORE_W  8   score counter width
// PORTS
//  clk             in   1      system clock
//  rst             in   1      asynchronous reset, active-low
//  frame_tick      in   1      one-cycle pulse per video frame
//  stage_x_in[0:1] in   10 ea  stage left edges from generate_stage
//  stage_w_in[0:1] in   10 ea  stage widths from generate_stage
//  stage_c_in[0:1] in   2 ea   stage colours from generate_stage
//  land_valid      in   1      one-cycle pulse: player has landed at land_x
//  land_x          in   10     player x at landing
//  land_ready      out  1      high only in IDLE; land_valid is accepted only when high
//  gen_enable      out  1      one-cycle request to generate_stage
//  disp_x[0:1]     out  10 ea  displayed stage left edges
//  disp_w[0:1]     out  10 ea  displayed stage widths
//  disp_c[0:1]     out  2 ea   displayed stage colours
//  score           out  SCORE_W  successful jumps, saturating at all-ones
//  game_over       out  1      sticky until reset
// BEHAVIOUR
//  Reset (rst=0, async): state=INIT; disp_x/w/c, score, remain all 0; gen_enable=0, game_over=0.
//  States: INIT -> WAIT -> LOAD -> IDLE -> JUDGE -> {IDLE | SCROLL | OVER}; SCROLL -> REQ -> WAIT.
//  INIT: gen_enable=1 for exactly one cycle; next WAIT.
//  REQ: gen_enable=1 for exactly one cycle; next WAIT.
//  WAIT: counts GEN_LAT cycles after the pulse; next LOAD.
//  LOAD: disp_* <= stage_*_in (all six fields, same edge); next IDLE.
//  IDLE: land_ready=1. On land_valid, latch land_x; next JUDGE. frame_tick ignored.
//  JUDGE (1 cycle): 11-bit compares, no overflow:
//   - hit target: disp_x[1] <= land_x < disp_x[1]+disp_w[1]. Score+1 (saturating);
//     remain <= disp_x[1]-HOME_X (0 if disp_x[1]<=HOME_X); next SCROLL.
//   - else hit home: disp_x[0] <= land_x < disp_x[0]+disp_w[0]. No score change; next IDLE.
//   - else: game_over<=1; next OVER.
//   - Ranges are half-open: land_x == x+w is a miss.
//  SCROLL: on each frame_tick, d = min(STEP, remain).
//   - disp_x[1] -= d; remain -= d.
//   - Home stage: if disp_x[0] >= d, disp_x[0] -= d;
//     else disp_w[0] <= sat0(disp_w[0]-(d-disp_x[0])) and disp_x[0] <= 0.
//   - remain==0 at SCROLL entry or after an update -> REQ on the next cycle. No movement without frame_tick.
//  OVER: terminal; land_valid and frame_tick ignored, disp_* and score frozen; only rst exits.
//  land_ready is 0 outside IDLE; a land_valid while land_ready=0 is dropped, not queued.
//  Reset mid-scroll or mid-wait aborts immediately; the sequence restarts at INIT.
//  Latencies:
//   - land_valid to score update: 2 cycles.
//   - remain==0 to gen_enable: 1 cycle.
//   - gen_enable to disp load: GEN_LAT+1 cycles.
// STRUCTURE
//  stage_pkg: state enum (INIT,WAIT,LOAD,IDLE,JUDGE,SCROLL,REQ,OVER); HOME_X default;
//  colour codes (BLUE etc., currently in parameter.v).
//  Sub-module stage_hit (combinational): x, w, px -> hit, used twice in JUDGE.
//  The FSM, scroll datapath and score counter stay in this module.
// TESTING
//  1 Reset release, stage_*_in={60,300},{60,40},{BLUE,RED}:
//    one gen_enable pulse, disp_* equal inputs GEN_LAT+1 cycles later, land_ready=1.
//  2 land_x=310 (target 300..339):
//    score 0->1; 60 frame_ticks move disp_x[1] 300->60, disp_x[0] 60->0 then disp_w[0] shrinks to 0;
//    gen_enable 1 cycle after remain=0.
//  3 land_x=100 (on home): score unchanged, no scroll, back to IDLE in 2 cycles.
//  4 land_x=200 (gap): game_over=1; later land_valid/frame_tick produce no change.
//  5 land_x=340 (x+w edge) -> miss.
//    Target at 62: single frame_tick moves by 2 only.
//  6 rst asserted mid-SCROLL -> all outputs 0 at once; restart at INIT.
//    255 hits saturate score at 255.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared types and constants for the stage scroller slice.
package stage_pkg;

    typedef enum logic [2:0] {
        INIT,
        WAIT,
        LOAD,
        IDLE,
        JUDGE,
        SCROLL,
        REQ,
        OVER
    } state_t;

    localparam int unsigned HOME_X_DEF = 60;

    localparam logic [1:0] BLACK = 2'd0;
    localparam logic [1:0] BLUE  = 2'd1;
    localparam logic [1:0] RED   = 2'd2;
    localparam logic [1:0] GREEN = 2'd3;

endpackage

// File: rtl/stage_hit.sv
// Half-open range test: hit when x <= px < x+w, evaluated at 11 bits so x+w never wraps.
module stage_hit
    import stage_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] w,
    input  logic [9:0] px,
    output logic       hit
);

    logic [10:0] x_e;
    logic [10:0] end_e;
    logic [10:0] px_e;

    // range compare
    always_comb begin
        x_e   = {1'b0, x};
        end_e = {1'b0, x} + {1'b0, w};
        px_e  = {1'b0, px};
        hit   = (px_e >= x_e) && (px_e < end_e);
    end

endmodule

// File: rtl/stage_scroller.sv
// Holds the home/target stages, judges landings, scrolls the target back to HOME_X
// and requests a fresh pair from the stage generator.
module stage_scroller
    import stage_pkg::*;
#(
    parameter int unsigned HOME_X  = HOME_X_DEF,
    parameter int unsigned STEP    = 4,
    parameter int unsigned GEN_LAT = 2,
    parameter int unsigned SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [9:0]         stage_x_in [0:1],
    input  logic [9:0]         stage_w_in [0:1],
    input  logic [1:0]         stage_c_in [0:1],
    input  logic               land_valid,
    input  logic [9:0]         land_x,
    output logic               land_ready,
    output logic               gen_enable,
    output logic [9:0]         disp_x [0:1],
    output logic [9:0]         disp_w [0:1],
    output logic [1:0]         disp_c [0:1],
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [9:0] HOME_V    = 10'(HOME_X);
    localparam logic [9:0] STEP_V    = 10'(STEP);
    // The pulse cycle itself counts toward the generator latency, so WAIT lasts GEN_LAT-1 cycles.
    localparam logic [7:0] WAIT_LAST = 8'(GEN_LAT - 2);

    state_t     state, state_nx;
    logic [9:0] remain;
    logic [9:0] land_q;
    logic [7:0] wcnt;
    logic [9:0] step_d;
    logic [9:0] home_def;
    logic       hit_home, hit_tgt;

    stage_hit u_hit_home (.x(disp_x[0]), .w(disp_w[0]), .px(land_q), .hit(hit_home));
    stage_hit u_hit_tgt  (.x(disp_x[1]), .w(disp_w[1]), .px(land_q), .hit(hit_tgt));

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nx;
    end

    // next-state and Moore outputs
    always_comb begin
        state_nx   = state;
        land_ready = 1'b0;
        gen_enable = 1'b0;
        case (state)
            INIT:   begin
                        gen_enable = rst;
                        state_nx   = WAIT;
                    end
            REQ:    begin
                        gen_enable = rst;
                        state_nx   = WAIT;
                    end
            WAIT:   if (wcnt == WAIT_LAST) state_nx = LOAD;
            LOAD:   state_nx = IDLE;
            IDLE:   begin
                        land_ready = 1'b1;
                        if (land_valid) state_nx = JUDGE;
                    end
            JUDGE:  begin
                        if (hit_tgt)       state_nx = SCROLL;
                        else if (hit_home) state_nx = IDLE;
                        else               state_nx = OVER;
                    end
            SCROLL: if (remain == '0) state_nx = REQ;
            OVER:   state_nx = OVER;
            default: state_nx = INIT;
        endcase
    end

    // per-frame scroll distance and how far it overruns the home stage's left edge
    always_comb begin
        step_d   = (remain < STEP_V) ? remain : STEP_V;
        home_def = step_d - disp_x[0];
    end

    // stage registers, scroll datapath, score and game-over flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_x[0] <= '0;
            disp_x[1] <= '0;
            disp_w[0] <= '0;
            disp_w[1] <= '0;
            disp_c[0] <= '0;
            disp_c[1] <= '0;
            score     <= '0;
            remain    <= '0;
            land_q    <= '0;
            wcnt      <= '0;
            game_over <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 8'd1 : '0;
            case (state)
                LOAD: begin
                    disp_x[0] <= stage_x_in[0];
                    disp_x[1] <= stage_x_in[1];
                    disp_w[0] <= stage_w_in[0];
                    disp_w[1] <= stage_w_in[1];
                    disp_c[0] <= stage_c_in[0];
                    disp_c[1] <= stage_c_in[1];
                end
                IDLE: if (land_valid) land_q <= land_x;
                JUDGE: begin
                    if (hit_tgt) begin
                        if (score != '1) score <= score + 1'b1;
                        remain <= (disp_x[1] > HOME_V) ? disp_x[1] - HOME_V : '0;
                    end else if (!hit_home) begin
                        game_over <= 1'b1;
                    end
                end
                SCROLL: if (frame_tick && remain != '0) begin
                    disp_x[1] <= disp_x[1] - step_d;
                    remain    <= remain - step_d;
                    if (disp_x[0] >= step_d) begin
                        disp_x[0] <= disp_x[0] - step_d;
                    end else begin
                        disp_x[0] <= '0;
                        disp_w[0] <= (disp_w[0] > home_def) ? disp_w[0] - home_def : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_scroller.sv
// Directed self-checking bench for stage_scroller.
module tb_stage_scroller;
    import stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [9:0] stage_x_in [0:1];
    logic [9:0] stage_w_in [0:1];
    logic [1:0] stage_c_in [0:1];
    logic       land_valid;
    logic [9:0] land_x;
    logic       land_ready;
    logic       gen_enable;
    logic [9:0] disp_x [0:1];
    logic [9:0] disp_w [0:1];
    logic [1:0] disp_c [0:1];
    logic [7:0] score;
    logic       game_over;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        mid_ready;

    stage_scroller #(.HOME_X(60), .STEP(4), .GEN_LAT(2), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .stage_x_in(stage_x_in), .stage_w_in(stage_w_in), .stage_c_in(stage_c_in),
        .land_valid(land_valid), .land_x(land_x), .land_ready(land_ready),
        .gen_enable(gen_enable), .disp_x(disp_x), .disp_w(disp_w), .disp_c(disp_c),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_stages(input logic [9:0] x0, x1, w0, w1, input logic [1:0] c0, c1);
        stage_x_in[0] = x0; stage_x_in[1] = x1;
        stage_w_in[0] = w0; stage_w_in[1] = w1;
        stage_c_in[0] = c0; stage_c_in[1] = c1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Pulse land_valid for one cycle; returns two cycles after the pulse.
    task automatic land(input logic [9:0] px);
        land_valid = 1'b1;
        land_x     = px;
        @(negedge clk);
        land_valid = 1'b0;
        mid_ready  = land_ready;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 50; k++) begin
            if (land_ready) break;
            @(negedge clk);
        end
        check(tag, {31'd0, land_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; land_valid = 1'b0; land_x = '0;
        set_stages(10'd60, 10'd300, 10'd60, 10'd40, BLUE, RED);
        repeat (3) @(negedge clk);
        #1;
        check("rst_gen",   {31'd0, gen_enable}, 32'd0);
        check("rst_ready", {31'd0, land_ready}, 32'd0);
        check("rst_x1",    {22'd0, disp_x[1]},  32'd0);
        check("rst_score", {24'd0, score},      32'd0);

        // 1: power-up sequence
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("init_gen", {31'd0, gen_enable}, 32'd1);
        @(negedge clk);
        check("init_gen_off", {31'd0, gen_enable}, 32'd0);
        check("init_x1_wait", {22'd0, disp_x[1]}, 32'd0);
        @(negedge clk);
        check("init_x1_load", {22'd0, disp_x[1]}, 32'd0);
        @(negedge clk);
        check("load_x0", {22'd0, disp_x[0]}, 32'd60);
        check("load_x1", {22'd0, disp_x[1]}, 32'd300);
        check("load_w0", {22'd0, disp_w[0]}, 32'd60);
        check("load_w1", {22'd0, disp_w[1]}, 32'd40);
        check("load_c0", {30'd0, disp_c[0]}, {30'd0, BLUE});
        check("load_c1", {30'd0, disp_c[1]}, {30'd0, RED});
        check("load_ready", {31'd0, land_ready}, 32'd1);

        // 2: target hit and full scroll
        land(10'd310);
        check("t2_mid_ready", {31'd0, mid_ready}, 32'd0);
        check("t2_score", {24'd0, score}, 32'd1);
        set_stages(10'd60, 10'd62, 10'd40, 10'd20, GREEN, BLUE);
        tick();
        check("t2_x1_1", {22'd0, disp_x[1]}, 32'd296);
        check("t2_x0_1", {22'd0, disp_x[0]}, 32'd56);
        repeat (14) tick();
        check("t2_x1_15", {22'd0, disp_x[1]}, 32'd240);
        check("t2_x0_15", {22'd0, disp_x[0]}, 32'd0);
        check("t2_w0_15", {22'd0, disp_w[0]}, 32'd60);
        land(10'd250);
        check("t2_drop_score", {24'd0, score}, 32'd1);
        check("t2_nomove", {22'd0, disp_x[1]}, 32'd240);
        tick();
        check("t2_w0_16", {22'd0, disp_w[0]}, 32'd56);
        repeat (14) tick();
        check("t2_w0_30", {22'd0, disp_w[0]}, 32'd0);
        check("t2_x1_30", {22'd0, disp_x[1]}, 32'd180);
        repeat (29) tick();
        check("t2_gen_pre", {31'd0, gen_enable}, 32'd0);
        tick();
        check("t2_x1_60", {22'd0, disp_x[1]}, 32'd60);
        check("t2_w0_60", {22'd0, disp_w[0]}, 32'd0);
        check("t2_gen_0", {31'd0, gen_enable}, 32'd0);
        @(negedge clk);
        check("t2_gen_1", {31'd0, gen_enable}, 32'd1);
        repeat (3) @(negedge clk);
        check("t2_reload_x1", {22'd0, disp_x[1]}, 32'd62);
        check("t2_reload_w0", {22'd0, disp_w[0]}, 32'd40);
        check("t2_reload_c0", {30'd0, disp_c[0]}, {30'd0, GREEN});
        check("t2_ready", {31'd0, land_ready}, 32'd1);

        // 5b: target two pixels from home moves by two only
        land(10'd70);
        check("t5_score", {24'd0, score}, 32'd2);
        set_stages(10'd60, 10'd300, 10'd60, 10'd40, BLUE, RED);
        tick();
        check("t5_x1", {22'd0, disp_x[1]}, 32'd60);
        check("t5_x0", {22'd0, disp_x[0]}, 32'd58);
        check("t5_gen_0", {31'd0, gen_enable}, 32'd0);
        @(negedge clk);
        check("t5_gen_1", {31'd0, gen_enable}, 32'd1);
        repeat (3) @(negedge clk);
        check("t5_reload_x1", {22'd0, disp_x[1]}, 32'd300);

        // 3: landing on home stage
        land(10'd100);
        check("t3_score", {24'd0, score}, 32'd2);
        check("t3_ready", {31'd0, land_ready}, 32'd1);
        check("t3_x1", {22'd0, disp_x[1]}, 32'd300);
        tick();
        check("t3_idle_tick", {22'd0, disp_x[1]}, 32'd300);

        // 5a: x+w edge is a miss
        land(10'd340);
        check("t5_edge_over", {31'd0, game_over}, 32'd1);
        check("t5_edge_ready", {31'd0, land_ready}, 32'd0);
        land(10'd310);
        tick();
        check("t5_over_score", {24'd0, score}, 32'd2);
        check("t5_over_x1", {22'd0, disp_x[1]}, 32'd300);
        check("t5_over_x0", {22'd0, disp_x[0]}, 32'd60);

        // 4: gap landing after a fresh start
        rst = 1'b0;
        #1;
        check("t4_rst_over", {31'd0, game_over}, 32'd0);
        check("t4_rst_score", {24'd0, score}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_ready("t4_ready");
        land(10'd200);
        check("t4_over", {31'd0, game_over}, 32'd1);
        check("t4_score", {24'd0, score}, 32'd0);
        land(10'd310);
        tick();
        check("t4_frozen_x1", {22'd0, disp_x[1]}, 32'd300);
        check("t4_sticky", {31'd0, game_over}, 32'd1);

        // 6: reset mid-scroll
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_ready("t6_ready");
        land(10'd310);
        repeat (5) tick();
        check("t6_x1", {22'd0, disp_x[1]}, 32'd280);
        rst = 1'b0;
        #1;
        check("t6_x1_rst", {22'd0, disp_x[1]}, 32'd0);
        check("t6_x0_rst", {22'd0, disp_x[0]}, 32'd0);
        check("t6_w0_rst", {22'd0, disp_w[0]}, 32'd0);
        check("t6_c1_rst", {30'd0, disp_c[1]}, 32'd0);
        check("t6_score_rst", {24'd0, score}, 32'd0);
        check("t6_gen_rst", {31'd0, gen_enable}, 32'd0);
        check("t6_ready_rst", {31'd0, land_ready}, 32'd0);
        set_stages(10'd0, 10'd60, 10'd10, 10'd40, BLACK, GREEN);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_restart_gen", {31'd0, gen_enable}, 32'd1);
        wait_ready("t6_ready2");
        check("t6_load_x1", {22'd0, disp_x[1]}, 32'd60);

        // 6: score saturation
        for (int i = 0; i < 256; i++) begin
            land(10'd70);
            if (i == 0)   check("sat_1", {24'd0, score}, 32'd1);
            if (i == 254) check("sat_255", {24'd0, score}, 32'd255);
            wait_ready("sat_ready");
        end
        check("sat_256", {24'd0, score}, 32'd255);
        check("sat_over", {31'd0, game_over}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
